// File: rtl/flipper_move_sequencer_if.sv
// Bundle between the keypad decoder, the move sequencer and the flipper position controller.
interface flipper_move_sequencer_if;
  logic               startOfFrame;
  logic               keyLeft;
  logic               keyRight;
  logic               pause;
  logic               reset_level;
  logic signed [10:0] ballCenterX;
  logic signed [10:0] flipperCenterX;
  logic               moveLeft;
  logic               moveRight;
  logic        [15:0] stepSpeed;
  logic               autoplayActive;

  modport master (
    output startOfFrame, keyLeft, keyRight, pause, reset_level, ballCenterX, flipperCenterX,
    input  moveLeft, moveRight, stepSpeed, autoplayActive
  );

  modport slave (
    input  startOfFrame, keyLeft, keyRight, pause, reset_level, ballCenterX, flipperCenterX,
    output moveLeft, moveRight, stepSpeed, autoplayActive
  );
endinterface

// File: rtl/flipper_move_sequencer.sv
// Per-frame flipper move sequencer: key arbitration, step-speed ramp and optional attract-mode
// autoplay (present only when FLIPPER_AUTOPLAY_EN is defined).
module flipper_move_sequencer #(
  parameter int unsigned IDLE_FRAMES = 600,
  parameter int unsigned DEADBAND    = 8,
  parameter int unsigned SPEED_MIN   = 200,
  parameter int unsigned SPEED_MAX   = 800,
  parameter int unsigned SPEED_STEP  = 100
) (
  input logic                     clk,
  input logic                     resetN,
  flipper_move_sequencer_if.slave bus
);
  localparam logic [1:0] DIR_NONE  = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;

  logic        key_left_d, key_right_d;
  logic        rise_left, rise_right;
  logic [1:0]  last_pressed, last_pressed_nxt;
  logic [1:0]  player_dir, dir, prev_dir;
  logic        move_left_q, move_right_q;
  logic [15:0] step_speed_q, speed_ramped;
  logic [16:0] speed_sum;
  logic        autoplay_q;

  // Edge detectors survive reset_level so last-pressed tracking stays coherent across a restart.
  always_comb begin
    rise_left  = bus.keyLeft  & ~key_left_d;
    rise_right = bus.keyRight & ~key_right_d;
  end

  always_comb begin
    last_pressed_nxt = last_pressed;
    if (rise_right)     last_pressed_nxt = DIR_RIGHT;
    else if (rise_left) last_pressed_nxt = DIR_LEFT;
  end

  always_comb begin
    player_dir = DIR_NONE;
    if (bus.keyLeft && bus.keyRight) player_dir = last_pressed_nxt;
    else if (bus.keyLeft)            player_dir = DIR_LEFT;
    else if (bus.keyRight)           player_dir = DIR_RIGHT;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_left_d   <= 1'b0;
      key_right_d  <= 1'b0;
      last_pressed <= DIR_NONE;
    end else begin
      key_left_d   <= bus.keyLeft;
      key_right_d  <= bus.keyRight;
      last_pressed <= last_pressed_nxt;
    end
  end

`ifdef FLIPPER_AUTOPLAY_EN
  localparam logic [0:0]         ST_MANUAL = 1'b0;
  localparam logic [0:0]         ST_AUTO   = 1'b1;
  localparam int unsigned        IDLE_W    = $clog2(IDLE_FRAMES + 1);
  localparam logic signed [11:0] DB        = 12'(DEADBAND);

  logic [0:0]         state;
  logic [IDLE_W-1:0]  idle_cnt;
  logic signed [11:0] diff;
  logic [1:0]         auto_dir;
  logic               any_key;

  always_comb begin
    any_key = bus.keyLeft | bus.keyRight;
    diff    = {bus.ballCenterX[10], bus.ballCenterX} - {bus.flipperCenterX[10], bus.flipperCenterX};
    auto_dir = DIR_NONE;
    if (diff > DB)       auto_dir = DIR_RIGHT;
    else if (diff < -DB) auto_dir = DIR_LEFT;
    dir        = (state == ST_AUTO) ? auto_dir : player_dir;
    autoplay_q = (state == ST_AUTO);
  end

  // The frame that completes the idle count still moves on player input; AUTO steers from the next one.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= ST_MANUAL;
      idle_cnt <= '0;
    end else if (bus.reset_level) begin
      state    <= ST_MANUAL;
      idle_cnt <= '0;
    end else if (state == ST_AUTO) begin
      if (any_key) state <= ST_MANUAL;
    end else if (any_key) begin
      idle_cnt <= '0;
    end else if (bus.startOfFrame && !bus.pause) begin
      if (idle_cnt >= IDLE_W'(IDLE_FRAMES - 1)) begin
        state    <= ST_AUTO;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end
`else
  logic unused_autoplay_inputs;

  always_comb begin
    dir        = player_dir;
    autoplay_q = 1'b0;
  end

  assign unused_autoplay_inputs = ^{bus.ballCenterX, bus.flipperCenterX,
                                    32'(IDLE_FRAMES), 32'(DEADBAND)};
`endif

  always_comb begin
    speed_sum    = {1'b0, step_speed_q} + 17'(SPEED_STEP);
    speed_ramped = (speed_sum > 17'(SPEED_MAX)) ? 16'(SPEED_MAX) : speed_sum[15:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      step_speed_q <= '0;
      prev_dir     <= DIR_NONE;
    end else if (bus.reset_level) begin
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      step_speed_q <= '0;
      prev_dir     <= DIR_NONE;
    end else if (bus.startOfFrame) begin
      if (bus.pause) begin
        move_left_q  <= 1'b0;
        move_right_q <= 1'b0;
      end else begin
        move_left_q  <= (dir == DIR_LEFT);
        move_right_q <= (dir == DIR_RIGHT);
        prev_dir     <= dir;
        if (dir == DIR_NONE)      step_speed_q <= '0;
        else if (dir == prev_dir) step_speed_q <= speed_ramped;
        else                      step_speed_q <= 16'(SPEED_MIN);
      end
    end
  end

  assign bus.moveLeft       = move_left_q;
  assign bus.moveRight      = move_right_q;
  assign bus.stepSpeed      = step_speed_q;
  assign bus.autoplayActive = autoplay_q;
endmodule

// File: doc/flipper_move_sequencer.md
# flipper_move_sequencer

Frame-rate sequencer that decides each frame whether the flipper moves left, right or not at all, and how fast. It arbitrates between the player's two direction keys and an attract-mode autoplay tracker that follows the ball. It also ramps the per-frame step size. It sits between the keypad decoder and the flipper position controller, and its outputs are the move requests that the controller samples on `startOfFrame`.

## Interface
- `IDLE_FRAMES`, 600: frames with no key held before autoplay engages (10 s at 60 Hz).
- `DEADBAND`, 8: autoplay dead zone in pixels around the ball/flipper centre difference.
- `SPEED_MIN`, 200: first-frame step, in fixed-point units (x`FIXED_POINT_MULTIPLIER`).
- `SPEED_MAX`, 800: step ceiling, same units.
- `SPEED_STEP`, 100: per-frame step increment while direction is held.
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-clock pulse per frame.
- `keyLeft`  in  1  player left key level.
- `keyRight`  in  1  player right key level.
- `pause`  in  1  game paused.
- `reset_level`  in  1  synchronous level restart.
- `ballCenterX`  in  11 signed  ball centre X, in pixels.
- `flipperCenterX`  in  11 signed  flipper centre X, in pixels.
- `moveLeft`  out  1  left move request for the current frame.
- `moveRight`  out  1  right move request for the current frame; never high together with `moveLeft`.
- `stepSpeed`  out  16 unsigned  per-frame displacement request, fixed point.
- `autoplayActive`  out  1  high while in the AUTO state.

## Operation
- Reset values (`resetN` low): `moveLeft`=0, `moveRight`=0, `stepSpeed`=0, `autoplayActive`=0, state MANUAL, idle counter 0, last-pressed=NONE.
- **Key arbitration** runs every clk, regardless of `startOfFrame`:
  - A rising edge of a key sets last-pressed to that key.
  - If both keys are held, last-pressed wins.
  - If only one key is held, that key wins.
  - Simultaneous rising edges of both keys select RIGHT.
- **State MANUAL:** the requested direction is the player direction.
  - On each `startOfFrame` with neither key held, the idle counter increments, saturating at `IDLE_FRAMES`.
  - Any held key clears the counter.
  - When the counter reaches `IDLE_FRAMES` at a `startOfFrame`, the state moves to AUTO and the counter is cleared.
- **State AUTO:**
  - diff = `ballCenterX` − `flipperCenterX`, computed at 12 bits signed.
  - diff > `DEADBAND` requests RIGHT; diff < −`DEADBAND` requests LEFT; otherwise NONE. Both bounds are exclusive.
  - Any key level high on any clk returns the state to MANUAL on the next clk. `autoplayActive` drops on that same edge.
- **Speed ramp**, evaluated only on `startOfFrame`:
  - Direction NONE: `stepSpeed`=0.
  - Direction equals the previous frame's non-NONE direction: `stepSpeed` = min(`stepSpeed`+`SPEED_STEP`, `SPEED_MAX`), with saturation computed at 17 bits.
  - New direction, or reversal: `stepSpeed`=`SPEED_MIN`.
  - `moveLeft`/`moveRight` are set from the chosen direction.
- **pause** high:
  - On `startOfFrame`, both moves are forced to 0.
  - `stepSpeed` holds its value and the previous direction holds.
  - The idle counter freezes.
  - State transitions still occur on a key press.
- **reset_level** high: synchronously restores all reset values except last-pressed. It has priority over `pause` and over `startOfFrame`.

## Timing
- All outputs are registered.
- Move and speed outputs update on the clk edge where `startOfFrame`=1 and hold for the whole frame.
- The consumer samples at the next `startOfFrame`, giving exactly one frame of latency from key/ball input to flipper motion.
- `autoplayActive` follows the state register: one clk after the transition decision.

## Configuration
- `FLIPPER_AUTOPLAY_EN` defined: AUTO state, idle counter and diff logic are present, as described above.
- `FLIPPER_AUTOPLAY_EN` undefined: the block is MANUAL only.
  - `autoplayActive` is tied to 0.
  - `ballCenterX` and `flipperCenterX` are unused.
  - The idle counter is removed.
  - Key arbitration and ramp behaviour are unchanged.

## Test plan
- Hold `keyRight` for 8 frames -> `moveRight`=1 and `stepSpeed` = 200, 300, 400, 500, 600, 700, 800, 800.
- Press `keyLeft`, then `keyRight` while left is still held, over 3 frames -> first frame `moveLeft`, then `moveRight` with `stepSpeed` reset to 200; never both high.
- No keys for 600 frames with `ballCenterX`=300, `flipperCenterX`=200 -> `autoplayActive`=1 and `moveRight`=1 from frame 601; press `keyLeft` -> `autoplayActive`=0 one clk later.
- AUTO with diff = +8 and diff = −8 -> no move and `stepSpeed`=0; diff = +9 -> `moveRight` at `SPEED_MIN`.
- Ramp to 500, assert `pause` for 3 frames, then release -> moves are 0 during pause; the next frame gives `stepSpeed`=600.
- Mid-ramp `reset_level` pulse coincident with `startOfFrame` -> all outputs 0 and state MANUAL on the next clk.
